fmadd_addlane_scheduler: RTL and testbench
==========================================

Name: fmadd_addlane_scheduler

Overview:
Shares the half-precision FMADD exponent-matching add lane between two requesters:
- port 0: direct FADD/FSUB operations from the decode/issue path.
- port 1: product-plus-addend operations from the FMADD multiplier output.

The block arbitrates round-robin, registers the winning operands, and drives them through the FMADD_Exponent_Matching datapath. It returns aligned results through a two-stage valid/ready pipeline, each result tagged with its source.

Parameters:
- man, 9, mantissa parameter. Lane mantissa width is 2*man+4 = 22 bits.
- exp, 4, exponent MSB index. Exponent width is exp+1 = 5 bits.
- std, 15, operand MSB index. Passed through to the datapath.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request valid, per port.
- req0_ready / req1_ready  out  1  request accepted this cycle, per port.
- reqN_sign_a, reqN_sign_b  in  1  operand signs (N = 0,1).
- reqN_exp_a, reqN_exp_b  in  exp+1  operand exponents.
- reqN_man_a, reqN_man_b  in  2*man+4  operand mantissas.
- reqN_opcode  in  2  [0]=add, [1]=sub.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- out_src  out  1  originating port.
- out_man_a, out_man_b  out  2*man+4  aligned mantissas.
- out_exp  out  exp+1  common exponent.
- out_sign  out  1  result sign.
- out_guard, out_round, out_sticky  out  1  rounding bits.
- out_eff_sub, out_eff_add  out  1  effective operation.
- busy  out  1  s1_v | s2_v.

Behaviour:
- Pipeline stages:
  - S1: operand register, with valid bit s1_v. Feeds the combinational datapath.
  - S2: result register, with valid bit s2_v. Drives all out_* ports.
- Advance conditions:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
- Arbitration:
  - A grant may occur only when s1_adv=1.
  - reqN_ready = grantN, exactly one-hot or zero.
  - At most one request is accepted per cycle.
  - Only one valid: that port wins.
  - Both valid: the port opposite rr_last wins; rr_last updates to the winner on every grant.
  - No grant leaves rr_last unchanged.
- S1 load: on grant, S1 captures the selected port's operands plus src, and s1_v=1. If s1_adv=1 with no grant, s1_v=0.
- S2 load: when s2_adv=1, S2 captures the datapath outputs plus src, and s2_v takes the value of s1_v.
- Latency: 2 cycles from the accepting edge to out_valid, with no back-pressure. Throughput is 1 op/cycle.
- Back-pressure:
  - out_valid=1 with out_ready=0 holds every out_* stable.
  - S1 holds when it is also full; both reqN_ready are then 0.
  - A full pipeline with out_ready rising accepts a new request in the same cycle (no bubble).
- Input holding: a requester must hold its payload while valid=1 and ready=0. Grants never retract mid-cycle.
- Datapath rules:
  - exp_a >= exp_b: b is shifted right by exp_a-exp_b, and out_exp=exp_a. Otherwise a is shifted and out_exp=exp_b.
  - A shift of 2*man+4 or more zeroes the shifted mantissa; sticky reflects the shifted-out bits.
- Reset: while rst=1 at a clock edge, s1_v=s2_v=0, rr_last=1 (port 0 wins the first contention), and all out_* data registers are 0. Consequently out_valid=0, reqN_ready=0 and busy=0. In-flight operations are discarded.

Optional Feature:
- Macro FMADD_ADDLANE_FLUSH_EN adds an input port flush (1 bit).
- With the macro: flush=1 clears s1_v and s2_v next edge, suppresses any grant that cycle (reqN_ready=0), and leaves rr_last unchanged. Data registers are don't-care. flush takes priority over all other updates except rst.
- Without the macro: no port, and no flush logic is synthesized.

Decomposition:
- Shared package fmadd_pkg:
  - constants MAN_W=2*man+4 and EXP_W=exp+1.
  - source IDs SRC_ADD=0 and SRC_FMA=1.
  - opcode encodings OP_ADD=2'b01 and OP_SUB=2'b10.
- Sub-module fmadd_rr_arbiter2: 2-input round-robin arbiter with rr_last state, inputs req[1:0] and en, output grant[1:0].
- The existing FMADD_Exponent_Matching is instantiated once, with std=15, man=9, exp=4.

Test Plan:
1. Single op, latency:
   - Stimulus: req0 only, add; exp_a=15, man_a=22'h200000; exp_b=13, man_b=22'h200000; out_ready=1.
   - Response: accepted cycle 0; out_valid cycle 2; out_exp=15; out_man_b=22'h080000; out_src=0; out_eff_add=1.
2. Contention after reset:
   - Stimulus: both ports valid for 4 cycles.
   - Response: grant order 0,1,0,1; out_src order identical.
3. Back-pressure:
   - Stimulus: out_ready=0 for 5 cycles with continuous req0.
   - Response: exactly 2 ops accepted, outputs held stable, then 1 result/cycle after out_ready=1 with none lost or duplicated.
4. Large shift:
   - Stimulus: exp_a=30, exp_b=1, man_b nonzero.
   - Response: out_man_b=0, out_sticky=1, out_exp=30.
5. Reset mid-operation:
   - Stimulus: assert rst with S1 and S2 full.
   - Response: next cycle out_valid=0, busy=0; the next contention grants port 0 first.
6. Flush (macro on):
   - Stimulus: flush with both stages full and both requests valid.
   - Response: no grant that cycle; out_valid=0 next cycle; rr_last preserved.

Source files
------------

// File: rtl/fmadd_pkg.sv
// Shared constants for the FMADD add-lane: lane widths, source IDs and opcode encodings.
package fmadd_pkg;

  localparam int MAN   = 9;
  localparam int EXP   = 4;
  localparam int STD   = 15;
  localparam int MAN_W = 2 * MAN + 4;
  localparam int EXP_W = EXP + 1;

  localparam logic SRC_ADD = 1'b0;
  localparam logic SRC_FMA = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  function automatic logic is_sub(input logic [1:0] op);
    return (op & OP_SUB) != 2'b00;
  endfunction

endpackage

// File: rtl/FMADD_Exponent_Matching.sv
// Exponent-matching datapath: shifts the smaller-exponent mantissa right, reporting guard/round/sticky.
module FMADD_Exponent_Matching
  import fmadd_pkg::*;
#(
  parameter int std = 15,
  parameter int man = 9,
  parameter int exp = 4
) (
  input  logic              sign_a_i,
  input  logic              sign_b_i,
  input  logic [exp:0]      exp_a_i,
  input  logic [exp:0]      exp_b_i,
  input  logic [2*man+3:0]  man_a_i,
  input  logic [2*man+3:0]  man_b_i,
  input  logic [1:0]        opcode_i,
  output logic [2*man+3:0]  man_a_o,
  output logic [2*man+3:0]  man_b_o,
  output logic [exp:0]      exp_o,
  output logic              sign_o,
  output logic              guard_o,
  output logic              round_o,
  output logic              sticky_o,
  output logic              eff_sub_o,
  output logic              eff_add_o
);

  localparam int W   = 2 * man + 4;
  localparam int PAD = 1 << (exp + 1);

  if (std < exp + 2) begin : g_bad_cfg
    $error("FMADD_Exponent_Matching: operand too narrow for exponent field");
  end

  logic           a_big;
  logic           a_mag_ge;
  logic           sign_b_eff;
  logic [exp:0]   shamt;
  logic [W-1:0]   shift_in;
  logic [W-1:0]   shifted;
  logic [W+PAD-1:0] wide;

  assign a_big    = exp_a_i >= exp_b_i;
  assign shamt    = a_big ? (exp_a_i - exp_b_i) : (exp_b_i - exp_a_i);
  assign shift_in = a_big ? man_b_i : man_a_i;

  // PAD exceeds the largest possible shift, so every shifted-out bit lands below the lane.
  assign wide     = {shift_in, {PAD{1'b0}}} >> shamt;
  assign shifted  = wide[W+PAD-1:PAD];
  assign guard_o  = wide[PAD-1];
  assign round_o  = wide[PAD-2];
  assign sticky_o = |wide[PAD-3:0];

  assign man_a_o = a_big ? man_a_i : shifted;
  assign man_b_o = a_big ? shifted : man_b_i;
  assign exp_o   = a_big ? exp_a_i : exp_b_i;

  // Result sign follows the larger-magnitude operand; a subtract flips b.
  assign sign_b_eff = sign_b_i ^ is_sub(opcode_i);
  assign a_mag_ge   = (exp_a_i > exp_b_i) || ((exp_a_i == exp_b_i) && (man_a_i >= man_b_i));
  assign sign_o     = a_mag_ge ? sign_a_i : sign_b_eff;

  assign eff_sub_o = sign_a_i ^ sign_b_eff;
  assign eff_add_o = ~eff_sub_o;

endmodule

// File: rtl/fmadd_rr_arbiter2.sv
// Two-input round-robin arbiter; rr_last holds the most recent winner (reset favours port 0).
module fmadd_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    grant     = 2'b00;
    rr_last_d = rr_last_q;
    if (en) begin
      // Port 0 wins alone, or under contention when port 1 won last.
      if (req[0] && (!req[1] || rr_last_q)) grant = 2'b01;
      else if (req[1])                      grant = 2'b10;
    end
    if (grant != 2'b00) rr_last_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/fmadd_addlane_scheduler.sv
// Round-robin scheduler sharing the exponent-matching lane between FADD (port 0) and FMADD (port 1).
// Optional FMADD_ADDLANE_FLUSH_EN adds a flush input that empties both pipeline stages.
module fmadd_addlane_scheduler
  import fmadd_pkg::*;
#(
  parameter int man = 9,
  parameter int exp = 4,
  parameter int std = 15
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FMADD_ADDLANE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_sign_a,
  input  logic              req0_sign_b,
  input  logic [exp:0]      req0_exp_a,
  input  logic [exp:0]      req0_exp_b,
  input  logic [2*man+3:0]  req0_man_a,
  input  logic [2*man+3:0]  req0_man_b,
  input  logic [1:0]        req0_opcode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_sign_a,
  input  logic              req1_sign_b,
  input  logic [exp:0]      req1_exp_a,
  input  logic [exp:0]      req1_exp_b,
  input  logic [2*man+3:0]  req1_man_a,
  input  logic [2*man+3:0]  req1_man_b,
  input  logic [1:0]        req1_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic [2*man+3:0]  out_man_a,
  output logic [2*man+3:0]  out_man_b,
  output logic [exp:0]      out_exp,
  output logic              out_sign,
  output logic              out_guard,
  output logic              out_round,
  output logic              out_sticky,
  output logic              out_eff_sub,
  output logic              out_eff_add,
  output logic              busy
);

  localparam int MW = 2 * man + 4;
  localparam int EW = exp + 1;

  // Handshake: a request transfers on a clock edge where reqN_valid && reqN_ready;
  // a result transfers where out_valid && out_ready. Payloads hold while valid && !ready.

  logic          kill;
  logic          s1_v_q, s2_v_q;
  logic          s1_adv, s2_adv;
  logic [1:0]    grant;

`ifdef FMADD_ADDLANE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign s2_adv = ~s2_v_q | out_ready;
  assign s1_adv = ~s1_v_q | s2_adv;

  fmadd_rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({req1_valid, req0_valid}),
    .en    (s1_adv & ~rst & ~kill),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  logic          s1_sign_a_q, s1_sign_b_q, s1_src_q;
  logic [EW-1:0] s1_exp_a_q, s1_exp_b_q;
  logic [MW-1:0] s1_man_a_q, s1_man_b_q;
  logic [1:0]    s1_opcode_q;
  logic          s1_sign_a_d, s1_sign_b_d, s1_src_d;
  logic [EW-1:0] s1_exp_a_d, s1_exp_b_d;
  logic [MW-1:0] s1_man_a_d, s1_man_b_d;
  logic [1:0]    s1_opcode_d;

  always_comb begin
    s1_src_d    = grant[1] ? SRC_FMA     : SRC_ADD;
    s1_sign_a_d = grant[1] ? req1_sign_a : req0_sign_a;
    s1_sign_b_d = grant[1] ? req1_sign_b : req0_sign_b;
    s1_exp_a_d  = grant[1] ? req1_exp_a  : req0_exp_a;
    s1_exp_b_d  = grant[1] ? req1_exp_b  : req0_exp_b;
    s1_man_a_d  = grant[1] ? req1_man_a  : req0_man_a;
    s1_man_b_d  = grant[1] ? req1_man_b  : req0_man_b;
    s1_opcode_d = grant[1] ? req1_opcode : req0_opcode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
    end else if (kill) begin
      s1_v_q <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= |grant;
      if (|grant) begin
        s1_src_q    <= s1_src_d;
        s1_sign_a_q <= s1_sign_a_d;
        s1_sign_b_q <= s1_sign_b_d;
        s1_exp_a_q  <= s1_exp_a_d;
        s1_exp_b_q  <= s1_exp_b_d;
        s1_man_a_q  <= s1_man_a_d;
        s1_man_b_q  <= s1_man_b_d;
        s1_opcode_q <= s1_opcode_d;
      end
    end
  end

  logic [MW-1:0] dp_man_a, dp_man_b;
  logic [EW-1:0] dp_exp;
  logic          dp_sign, dp_guard, dp_round, dp_sticky, dp_eff_sub, dp_eff_add;

  FMADD_Exponent_Matching #(
    .std (std),
    .man (man),
    .exp (exp)
  ) u_expm (
    .sign_a_i  (s1_sign_a_q),
    .sign_b_i  (s1_sign_b_q),
    .exp_a_i   (s1_exp_a_q),
    .exp_b_i   (s1_exp_b_q),
    .man_a_i   (s1_man_a_q),
    .man_b_i   (s1_man_b_q),
    .opcode_i  (s1_opcode_q),
    .man_a_o   (dp_man_a),
    .man_b_o   (dp_man_b),
    .exp_o     (dp_exp),
    .sign_o    (dp_sign),
    .guard_o   (dp_guard),
    .round_o   (dp_round),
    .sticky_o  (dp_sticky),
    .eff_sub_o (dp_eff_sub),
    .eff_add_o (dp_eff_add)
  );

  logic          s2_src_q, s2_sign_q, s2_guard_q, s2_round_q, s2_sticky_q;
  logic          s2_eff_sub_q, s2_eff_add_q;
  logic [MW-1:0] s2_man_a_q, s2_man_b_q;
  logic [EW-1:0] s2_exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q       <= 1'b0;
      s2_src_q     <= 1'b0;
      s2_man_a_q   <= '0;
      s2_man_b_q   <= '0;
      s2_exp_q     <= '0;
      s2_sign_q    <= 1'b0;
      s2_guard_q   <= 1'b0;
      s2_round_q   <= 1'b0;
      s2_sticky_q  <= 1'b0;
      s2_eff_sub_q <= 1'b0;
      s2_eff_add_q <= 1'b0;
    end else if (kill) begin
      s2_v_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q       <= s1_v_q;
      s2_src_q     <= s1_src_q;
      s2_man_a_q   <= dp_man_a;
      s2_man_b_q   <= dp_man_b;
      s2_exp_q     <= dp_exp;
      s2_sign_q    <= dp_sign;
      s2_guard_q   <= dp_guard;
      s2_round_q   <= dp_round;
      s2_sticky_q  <= dp_sticky;
      s2_eff_sub_q <= dp_eff_sub;
      s2_eff_add_q <= dp_eff_add;
    end
  end

  assign out_valid   = s2_v_q;
  assign out_src     = s2_src_q;
  assign out_man_a   = s2_man_a_q;
  assign out_man_b   = s2_man_b_q;
  assign out_exp     = s2_exp_q;
  assign out_sign    = s2_sign_q;
  assign out_guard   = s2_guard_q;
  assign out_round   = s2_round_q;
  assign out_sticky  = s2_sticky_q;
  assign out_eff_sub = s2_eff_sub_q;
  assign out_eff_add = s2_eff_add_q;
  assign busy        = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_fmadd_addlane_scheduler.sv
// Randomized bench for fmadd_addlane_scheduler with an arithmetic reference model and scoreboard.
`timescale 1ns/1ps
module tb_fmadd_addlane_scheduler;
  import fmadd_pkg::*;

  typedef struct packed {
    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] ma;
    logic [MAN_W-1:0] mb;
    logic [1:0]       op;
  } req_t;

  localparam int PKT_W = 1 + 2 * MAN_W + EXP_W + 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  req_t r0 = '0, r1 = '0;
`ifdef FMADD_ADDLANE_FLUSH_EN
  logic flush = 1'b0;
`endif

  logic             req0_ready, req1_ready, out_valid, out_src, out_sign;
  logic             out_guard, out_round, out_sticky, out_eff_sub, out_eff_add, busy;
  logic [MAN_W-1:0] out_man_a, out_man_b;
  logic [EXP_W-1:0] out_exp;

  fmadd_addlane_scheduler dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FMADD_ADDLANE_FLUSH_EN
    .flush       (flush),
`endif
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_sign_a (r0.sa),
    .req0_sign_b (r0.sb),
    .req0_exp_a  (r0.ea),
    .req0_exp_b  (r0.eb),
    .req0_man_a  (r0.ma),
    .req0_man_b  (r0.mb),
    .req0_opcode (r0.op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_sign_a (r1.sa),
    .req1_sign_b (r1.sb),
    .req1_exp_a  (r1.ea),
    .req1_exp_b  (r1.eb),
    .req1_man_a  (r1.ma),
    .req1_man_b  (r1.mb),
    .req1_opcode (r1.op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_src     (out_src),
    .out_man_a   (out_man_a),
    .out_man_b   (out_man_b),
    .out_exp     (out_exp),
    .out_sign    (out_sign),
    .out_guard   (out_guard),
    .out_round   (out_round),
    .out_sticky  (out_sticky),
    .out_eff_sub (out_eff_sub),
    .out_eff_add (out_eff_add),
    .busy        (busy)
  );

  logic [PKT_W-1:0] out_pkt;
  assign out_pkt = {out_src, out_man_a, out_man_b, out_exp, out_sign,
                    out_guard, out_round, out_sticky, out_eff_sub, out_eff_add};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PKT_W-1:0] exp_q[$];
  logic rr_last_m  = 1'b1;
  logic acc_last_m = 1'b0;
  logic acc0_m = 1'b0, acc1_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: align the smaller-exponent operand by plain integer shifts.
  function automatic logic [PKT_W-1:0] ref_align(input logic src, input req_t r);
    int sh;
    longint m;
    logic [MAN_W-1:0] oa, ob, sm;
    logic [EXP_W-1:0] e;
    logic g, rd, st, sub, sg, es;
    sub = (r.op == OP_SUB);
    if (r.ea >= r.eb) begin sh = int'(r.ea) - int'(r.eb); m = longint'(r.mb); e = r.ea; end
    else              begin sh = int'(r.eb) - int'(r.ea); m = longint'(r.ma); e = r.eb; end
    sm = (sh >= MAN_W) ? '0 : MAN_W'(m >> sh);
    g  = (sh >= 1) ? (((m >> (sh - 1)) & 64'd1) != 0) : 1'b0;
    rd = (sh >= 2) ? (((m >> (sh - 2)) & 64'd1) != 0) : 1'b0;
    st = (sh >= 3) ? ((m & ((64'd1 << (sh - 2)) - 64'd1)) != 0) : 1'b0;
    oa = (r.ea >= r.eb) ? r.ma : sm;
    ob = (r.ea >= r.eb) ? sm : r.mb;
    if ((r.ea > r.eb) || ((r.ea == r.eb) && (r.ma >= r.mb))) sg = r.sa;
    else                                                      sg = r.sb ^ sub;
    es = r.sa ^ r.sb ^ sub;
    return {src, oa, ob, e, sg, g, rd, st, es, ~es};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.sa = 1'($urandom_range(0, 1));
    r.sb = 1'($urandom_range(0, 1));
    r.ea = EXP_W'($urandom_range(0, 31));
    r.eb = ($urandom_range(0, 3) == 0) ? r.ea : EXP_W'($urandom_range(0, 31));
    r.ma = MAN_W'($urandom);
    r.mb = MAN_W'($urandom);
    r.op = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
    return r;
  endfunction

  // One clock: check handshake/outputs mid-cycle, then update the model at the edge.
  task automatic cycle();
    logic [1:0] g_exp;
    logic can, acc0, acc1, pop;
    logic [PKT_W-1:0] p0, p1;
    @(negedge clk);
    can = (exp_q.size() < 2) || out_ready;
    g_exp[0] = can && req0_valid && (!req1_valid || rr_last_m);
    g_exp[1] = can && req1_valid && (!req0_valid || !rr_last_m);
`ifdef FMADD_ADDLANE_FLUSH_EN
    if (flush) g_exp = 2'b00;
`endif
    check("ready", {req1_ready, req0_ready}, g_exp);
    check("busy", busy, exp_q.size() != 0);
    check("out_valid", out_valid, (exp_q.size() == 2) || (exp_q.size() == 1 && !acc_last_m));
    if (out_valid && exp_q.size() > 0) check("result", out_pkt, exp_q[0]);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    pop  = out_valid && out_ready;
    p0 = ref_align(SRC_ADD, r0);
    p1 = ref_align(SRC_FMA, r1);
    @(posedge clk);
    if (pop && exp_q.size() > 0) exp_q.delete(0);
    if (acc0) begin exp_q.push_back(p0); rr_last_m = 1'b0; end
    if (acc1) begin exp_q.push_back(p1); rr_last_m = 1'b1; end
`ifdef FMADD_ADDLANE_FLUSH_EN
    if (flush) begin exp_q.delete(); acc0 = 1'b0; acc1 = 1'b0; end
`endif
    acc_last_m = acc0 | acc1;
    acc0_m = acc0;
    acc1_m = acc1;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic refresh();
    if (acc0_m) r0 = rand_req();
    if (acc1_m) r1 = rand_req();
  endtask

  task automatic drive_random(input int p_valid, input int p_ready);
    if (!req0_valid || acc0_m) begin
      req0_valid = ($urandom_range(0, 99) < p_valid);
      r0 = rand_req();
    end
    if (!req1_valid || acc1_m) begin
      req1_valid = ($urandom_range(0, 99) < p_valid);
      r1 = rand_req();
    end
    out_ready = ($urandom_range(0, 99) < p_ready);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    check("rst_data", out_pkt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    rr_last_m = 1'b1;
    acc_last_m = 1'b0;
    acc0_m = 1'b0;
    acc1_m = 1'b0;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [PKT_W-1:0] held;

    do_reset();

    // Single op latency.
    out_ready = 1'b1;
    r0 = '{sa: 1'b0, sb: 1'b0, ea: 5'd15, eb: 5'd13, ma: 22'h200000, mb: 22'h200000, op: OP_ADD};
    req0_valid = 1'b1;
    #1;
    check("t1_ready", req0_ready, 1);
    cycle();
    req0_valid = 1'b0;
    check("t1_lat1", out_valid, 0);
    cycle();
    check("t1_lat2", out_valid, 1);
    check("t1_exp", out_exp, 15);
    check("t1_man_b", out_man_b, 22'h080000);
    check("t1_src", out_src, 0);
    check("t1_eff_add", out_eff_add, 1);
    drain();

    // Contention after reset: 0,1,0,1.
    do_reset();
    out_ready = 1'b1;
    r0 = rand_req();
    r1 = rand_req();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      cycle();
      refresh();
    end
    drain();

    // Back-pressure with continuous req0.
    out_ready = 1'b0;
    r0 = rand_req();
    req0_valid = 1'b1;
    cnt = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (req0_ready) cnt++;
      if (i == 2) held = out_pkt;
      cycle();
      refresh();
    end
    check("t3_accepts", cnt, 2);
    check("t3_hold", out_pkt, held);
    out_ready = 1'b1;
    #1;
    check("t3_nobubble", req0_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      refresh();
    end
    drain();

    // Large shift: everything shifted out into sticky.
    out_ready = 1'b1;
    r0 = '{sa: 1'b0, sb: 1'b1, ea: 5'd30, eb: 5'd1, ma: 22'h2abcde, mb: 22'h000123, op: OP_SUB};
    req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    cycle();
    check("t4_valid", out_valid, 1);
    check("t4_man_b", out_man_b, 0);
    check("t4_sticky", out_sticky, 1);
    check("t4_exp", out_exp, 30);
    drain();

    // Reset mid-operation with both stages full.
    out_ready = 1'b0;
    r0 = rand_req();
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      refresh();
    end
    check("t5_busy_before", busy, 1);
    do_reset();
    r0 = rand_req();
    r1 = rand_req();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t5_first", {req1_ready, req0_ready}, 2'b01);
    cycle();
    refresh();
    drain();

`ifdef FMADD_ADDLANE_FLUSH_EN
    // Flush with both stages full and both requests pending.
    out_ready = 1'b0;
    r0 = rand_req();
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      refresh();
    end
    r1 = rand_req();
    req1_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_grant", {req1_ready, req0_ready}, 2'b00);
    cycle();
    flush = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_busy", busy, 0);
    #1;
    check("fl_rr_kept", {req1_ready, req0_ready}, 2'b10);
    cycle();
    refresh();
    drain();
`endif

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      drive_random(70, 65);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
